fpc_rr_mux_n: RTL and testbench
===============================

// Module: fpc_rr_mux_n
// PURPOSE
//  Parametrised successor of the 4-channel FPC read-request mux. It takes per-channel DMA
//  ranges (8-byte units) from the request units and splits each into block-sized read requests.
//  It arbitrates round-robin across NCHAN channels, gated by per-channel tag availability, and
//  issues one tagged request per cycle to the PCIe TX read-request path.
//  Adds: N channels, configurable block size, single-cycle skip of idle channels, per-channel abort.
// PARAMETERS
//  NCHAN         4     channels, 1..8
//  ENABLE        8'hFF channel enable mask, bit i enables channel i; disabled channels are tied off
//  NBITS_TAG_LOW 3     tag bits supplied per channel by its tag allocator
//  ADDR_W        61    request address width, 8-byte units
//  COUNT_W       19    range length width, 8-byte units
//  BLOCK_SHIFT   3     log2(block size in 8-byte words); 3 = 64-byte read requests
//  CHAN_W        3     channel field width in tag; CHAN_W+NBITS_TAG_LOW <= 8
// PORTS
//  clock       in   1                     rising-edge clock
//  reset       in   1                     asynchronous, active-high reset
//  r_valid     in   NCHAN                 range load strobe, per channel
//  r_addr      in   ADDR_W                range start (shared bus, qualified by r_valid[i])
//  r_count     in   COUNT_W               range length (shared bus)
//  r_ready     out  NCHAN                 channel idle, may accept a range
//  r_abort     in   NCHAN                 discard remaining blocks of channel i
//  busy        out  NCHAN                 remaining block count of channel i != 0
//  rr_valid    in   NCHAN                 tag available for channel i
//  rr_tag_low  in   NCHAN*NBITS_TAG_LOW   tag value per channel
//  rr_ready    out  NCHAN                 tag consumed, one-cycle pulse on grant
//  rrm_valid   out  1                     multiplexed request valid
//  rrm_addr    out  ADDR_W-BLOCK_SHIFT    block address
//  rrm_tag     out  8                     {zero pad, chan[CHAN_W-1:0], tag_low}
//  rrm_ready   in   1                     downstream accepts request
// BEHAVIOUR
//  - Reset (async): remaining=0, rrm_valid=0, rrm_addr=0, rrm_tag=0, last_grant=NCHAN-1 (ch0 first).
//  - r_ready[i] = ENABLE[i] & (remaining[i]==0). A load occurs when r_valid[i] & r_ready[i]:
//    addr[i] <= r_addr>>BLOCK_SHIFT; remaining[i] <= r_count>>BLOCK_SHIFT.
//    A load with a zero block count leaves the channel idle. r_valid on a busy channel is ignored.
//  - eligible[i] = ENABLE[i] & remaining[i]!=0 & rr_valid[i] & ~r_abort[i].
//  - Slot free = ~rrm_valid | rrm_ready. When the slot is free and any channel is eligible, the
//    arbiter grants the first eligible channel searching last_grant+1 .. last_grant+NCHAN (mod
//    NCHAN), combinationally in that cycle, so idle channels cost no cycles.
//  - Grant to channel g, same cycle: rr_ready[g]=1; registered: rrm_valid<=1, rrm_addr<=addr[g],
//    rrm_tag<={g, tag_low[g]}, addr[g]+=1, remaining[g]-=1, last_grant<=g.
//  - Slot free and no channel eligible: rrm_valid<=0. Otherwise rrm_* hold stable while
//    rrm_valid & ~rrm_ready.
//  - Throughput: one request per cycle. Latency: grant to rrm_valid is 1 cycle.
//  - rrm_addr wraps modulo 2^(ADDR_W-BLOCK_SHIFT); no carry out; ranges must not cross it.
//  - r_abort[i]: remaining[i]<=0 next cycle. A request already held in rrm_* still completes.
//    The channel is not granted in the abort cycle. Abort concurrent with load: load wins.
//  - rr_ready is never asserted for disabled or non-granted channels; at most one bit is set.
//  - Reset mid-transfer drops the held request and all remaining counts; no rr_ready pulse occurs.
// TESTING
//  1 ch0 load addr=0x40 count=32, rr_valid=1, rrm_ready=1 -> 4 requests, addr 0x8..0xB,
//    tag 0x00|tag_low, back-to-back; r_ready[0] rises after the 4th.
//  2 ch0,ch1,ch3 loaded with 3 blocks each, all tags valid -> grant order 0,1,3,0,1,3,0,1,3 with
//    no bubble for ch2.
//  3 rrm_ready held low 5 cycles mid-stream -> rrm_addr/rrm_tag stable, no rr_ready pulses,
//    no count change; resumes in order.
//  4 ch1 loaded, rr_valid[1]=0 for 10 cycles -> rrm_valid=0, busy[1]=1; on rr_valid[1]=1 a
//    request follows 1 cycle later.
//  5 ch2 with 100 blocks, r_abort[2] after 5 issued -> at most 6 requests total, busy[2]=0,
//    r_ready[2]=1.
//  6 async reset asserted while rrm_valid=1 -> outputs 0 immediately, no clock edge needed;
//    after release the first grant is ch0.

Source files
------------

// File: rtl/fpc_rr_mux_n_if.sv
// -----------------------------------------------------------------------------
// fpc_rr_mux_n_if
// Purpose : bundles the range-load, tag-allocator and multiplexed read-request
//           signals of fpc_rr_mux_n.
// Signals : r_valid/r_addr/r_count/r_abort  -> range load and abort per channel
//           r_ready/busy                     <- channel idle / blocks remaining
//           rr_valid/rr_tag_low              -> per-channel tag availability
//           rr_ready                         <- tag consumed (grant pulse)
//           rrm_valid/rrm_addr/rrm_tag       <- multiplexed block read request
//           rrm_ready                        -> downstream accepts request
// Modports: master = request/tag side driving the mux, slave = the mux itself.
// -----------------------------------------------------------------------------
interface fpc_rr_mux_n_if #(
   parameter int NCHAN         = 4,
   parameter int NBITS_TAG_LOW = 3,
   parameter int ADDR_W        = 61,
   parameter int COUNT_W       = 19,
   parameter int BLOCK_SHIFT   = 3
);
   logic [NCHAN-1:0]               r_valid;
   logic [ADDR_W-1:0]              r_addr;
   logic [COUNT_W-1:0]             r_count;
   logic [NCHAN-1:0]               r_ready;
   logic [NCHAN-1:0]               r_abort;
   logic [NCHAN-1:0]               busy;
   logic [NCHAN-1:0]               rr_valid;
   logic [NCHAN*NBITS_TAG_LOW-1:0] rr_tag_low;
   logic [NCHAN-1:0]               rr_ready;
   logic                           rrm_valid;
   logic [ADDR_W-BLOCK_SHIFT-1:0]  rrm_addr;
   logic [7:0]                     rrm_tag;
   logic                           rrm_ready;

   modport master (
      output r_valid, r_addr, r_count, r_abort, rr_valid, rr_tag_low, rrm_ready,
      input  r_ready, busy, rr_ready, rrm_valid, rrm_addr, rrm_tag
   );

   modport slave (
      input  r_valid, r_addr, r_count, r_abort, rr_valid, rr_tag_low, rrm_ready,
      output r_ready, busy, rr_ready, rrm_valid, rrm_addr, rrm_tag
   );
endinterface

// File: rtl/fpc_rr_mux_n.sv
// -----------------------------------------------------------------------------
// fpc_rr_mux_n
// Purpose : splits per-channel DMA ranges (8-byte units) into block-sized read
//           requests and multiplexes them round-robin onto one tagged request
//           stream, one request per cycle, gated by per-channel tag availability.
// Ports   : i_clk  - rising-edge clock
//           i_rst  - asynchronous active-high reset
//           io_bus - fpc_rr_mux_n_if.slave (range load, abort, busy, tag
//                    handshake, multiplexed request output)
// -----------------------------------------------------------------------------
module fpc_rr_mux_n #(
   parameter int         NCHAN         = 4,
   parameter logic [7:0] ENABLE        = 8'hFF,
   parameter int         NBITS_TAG_LOW = 3,
   parameter int         ADDR_W        = 61,
   parameter int         COUNT_W       = 19,
   parameter int         BLOCK_SHIFT   = 3,
   parameter int         CHAN_W        = 3
) (
   input logic           i_clk,
   input logic           i_rst,
   fpc_rr_mux_n_if.slave io_bus
);
   localparam int BADDR_W = ADDR_W - BLOCK_SHIFT;
   localparam int REM_W   = COUNT_W - BLOCK_SHIFT;
   localparam int NB      = NBITS_TAG_LOW;

   // per-channel views
   logic [NCHAN-1:0]   w_rem_nz;
   logic [NCHAN-1:0]   w_eligible;
   logic [NCHAN-1:0]   w_r_ready;
   logic [BADDR_W-1:0] w_chan_addr [NCHAN];
   logic [NB-1:0]      w_tag_low   [NCHAN];

   // arbitration
   logic               w_slot_free;
   logic               w_found;
   logic [CHAN_W-1:0]  w_grant_idx;
   logic [NCHAN-1:0]   w_grant_oh;
   logic [7:0]         w_tag_next;

   // output stage
   logic               r_rrm_valid;
   logic [BADDR_W-1:0] r_rrm_addr;
   logic [7:0]         r_rrm_tag;
   logic [CHAN_W-1:0]  r_last_grant;

   // Sub-block address bits and inputs of disabled channels are not needed.
   logic w_unused;
   assign w_unused = ^{io_bus.r_valid, io_bus.r_addr, io_bus.r_count, io_bus.r_abort};

   genvar gi;
   generate
      for (gi = 0; gi < NCHAN; gi++) begin : g_chan
         if (ENABLE[gi]) begin : g_en
            logic [REM_W-1:0]   r_remaining;
            logic [BADDR_W-1:0] r_addr;
            logic               w_load;

            // Only an idle channel accepts a range; a busy one ignores r_valid.
            assign w_load = io_bus.r_valid[gi] & (r_remaining == '0);

            // Load, abort and grant are mutually exclusive in effect: a load
            // needs remaining==0, a grant needs remaining!=0 and no abort,
            // and a load takes priority over a concurrent abort.
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  r_remaining <= '0;
                  r_addr      <= '0;
               end else if (w_load) begin
                  r_remaining <= io_bus.r_count[COUNT_W-1:BLOCK_SHIFT];
                  r_addr      <= io_bus.r_addr[ADDR_W-1:BLOCK_SHIFT];
               end else if (io_bus.r_abort[gi]) begin
                  r_remaining <= '0;
               end else if (w_grant_oh[gi]) begin
                  r_remaining <= r_remaining - REM_W'(1);
                  r_addr      <= r_addr + BADDR_W'(1);
               end
            end

            assign w_rem_nz[gi]    = (r_remaining != '0);
            assign w_chan_addr[gi] = r_addr;
         end else begin : g_off
            assign w_rem_nz[gi]    = 1'b0;
            assign w_chan_addr[gi] = '0;
         end

         assign w_tag_low[gi]  = io_bus.rr_tag_low[gi*NB +: NB];
         // w_rem_nz already implies the channel is enabled.
         assign w_eligible[gi] = w_rem_nz[gi] & io_bus.rr_valid[gi] & ~io_bus.r_abort[gi];
         assign w_r_ready[gi]  = ENABLE[gi] & ~w_rem_nz[gi];
      end
   endgenerate

   assign w_slot_free = ~r_rrm_valid | io_bus.rrm_ready;

   // Round-robin search from last_grant+1, wrapping; the whole search is
   // combinational so channels with nothing to do cost no cycles.
   always_comb begin
      int                t;
      logic [CHAN_W-1:0] idx;
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_grant_oh  = '0;
      for (int k = 1; k <= NCHAN; k++) begin
         t = int'(r_last_grant) + k;
         if (t >= NCHAN) t = t - NCHAN;
         idx = CHAN_W'(t);
         if (!w_found && w_eligible[idx]) begin
            w_found     = 1'b1;
            w_grant_idx = idx;
         end
      end
      if (w_slot_free && w_found) w_grant_oh[w_grant_idx] = 1'b1;
   end

   // Tag layout: {zero pad, channel, tag_low}.
   always_comb begin
      w_tag_next                 = '0;
      w_tag_next[NB +: CHAN_W]   = w_grant_idx;
      w_tag_next[NB-1:0]         = w_tag_low[w_grant_idx];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rrm_valid  <= 1'b0;
         r_rrm_addr   <= '0;
         r_rrm_tag    <= '0;
         r_last_grant <= CHAN_W'(NCHAN - 1);
      end else if (w_slot_free) begin
         if (w_found) begin
            r_rrm_valid  <= 1'b1;
            r_rrm_addr   <= w_chan_addr[w_grant_idx];
            r_rrm_tag    <= w_tag_next;
            r_last_grant <= w_grant_idx;
         end else begin
            r_rrm_valid  <= 1'b0;
         end
      end
   end

   assign io_bus.r_ready   = w_r_ready;
   assign io_bus.busy      = w_rem_nz;
   assign io_bus.rr_ready  = w_grant_oh;
   assign io_bus.rrm_valid = r_rrm_valid;
   assign io_bus.rrm_addr  = r_rrm_addr;
   assign io_bus.rrm_tag   = r_rrm_tag;
endmodule

// File: tb/tb_fpc_rr_mux_n.sv
// -----------------------------------------------------------------------------
// tb_fpc_rr_mux_n
// Purpose : self-checking bench for fpc_rr_mux_n; expected requests are queued
//           when ranges are loaded and compared as the mux delivers them.
// -----------------------------------------------------------------------------
module tb_fpc_rr_mux_n;
   localparam int NCHAN   = 4;
   localparam int NB      = 3;
   localparam int ADDR_W  = 61;
   localparam int COUNT_W = 19;
   localparam int BSH     = 3;

   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  tag;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // per-channel tag_low values driven on rr_tag_low
   logic [2:0] tl_tab [NCHAN];

   fpc_rr_mux_n_if #(
      .NCHAN(NCHAN), .NBITS_TAG_LOW(NB), .ADDR_W(ADDR_W),
      .COUNT_W(COUNT_W), .BLOCK_SHIFT(BSH)
   ) u_if ();

   fpc_rr_mux_n #(
      .NCHAN(NCHAN), .ENABLE(8'hFF), .NBITS_TAG_LOW(NB), .ADDR_W(ADDR_W),
      .COUNT_W(COUNT_W), .BLOCK_SHIFT(BSH), .CHAN_W(3)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [63:0] blk_addr);
      exp_t e;
      e.addr = blk_addr;
      e.tag  = 8'((ch << 3) | int'(tl_tab[ch]));
      sb_q.push_back(e);
   endtask

   task automatic load(input int ch, input logic [60:0] addr, input logic [18:0] count);
      u_if.r_valid     = '0;
      u_if.r_valid[ch] = 1'b1;
      u_if.r_addr      = addr;
      u_if.r_count     = count;
      tick();
      u_if.r_valid     = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      u_if.r_valid = '0;
      u_if.r_abort = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 64'(sb_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: every accepted request is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("rr_ready_onehot0", 64'($onehot0(u_if.rr_ready)), 64'd1);
         if (u_if.rrm_valid && u_if.rrm_ready) begin
            $display("REQ addr=0x%0h tag=0x%02h", u_if.rrm_addr, u_if.rrm_tag);
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
               e = sb_q.pop_front();
               chk("sb_addr", 64'(u_if.rrm_addr), e.addr);
               chk("sb_tag", 64'(u_if.rrm_tag), 64'(e.tag));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int n;
      int order [3];
      logic [63:0] base [NCHAN];

      tl_tab[0] = 3'd1; tl_tab[1] = 3'd4; tl_tab[2] = 3'd7; tl_tab[3] = 3'd2;
      clk = 1'b0;
      rst = 1'b1;
      u_if.r_valid    = '0;
      u_if.r_addr     = '0;
      u_if.r_count    = '0;
      u_if.r_abort    = '0;
      u_if.rr_valid   = '0;
      u_if.rr_tag_low = {tl_tab[3], tl_tab[2], tl_tab[1], tl_tab[0]};
      u_if.rrm_ready  = 1'b1;

      // reset state
      #3;
      chk("rst_rrm_valid", 64'(u_if.rrm_valid), 64'd0);
      chk("rst_rrm_addr", 64'(u_if.rrm_addr), 64'd0);
      chk("rst_rrm_tag", 64'(u_if.rrm_tag), 64'd0);
      chk("rst_r_ready", 64'(u_if.r_ready), 64'hF);
      chk("rst_busy", 64'(u_if.busy), 64'd0);

      // 1: single channel, 4 back-to-back blocks
      do_reset();
      u_if.rr_valid = 4'hF;
      for (int i = 0; i < 4; i++) push(0, 64'h8 + 64'(i));
      load(0, 61'h40, 19'd32);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_r_ready_low", 64'(u_if.r_ready[0]), 64'd0);
         chk("t1_grant", 64'(u_if.rr_ready), 64'h1);
         tick();
         chk("t1_b2b_valid", 64'(u_if.rrm_valid), 64'd1);
      end
      chk("t1_r_ready_rise", 64'(u_if.r_ready[0]), 64'd1);
      wait_drain("t1_drain", 20);
      tick();
      chk("t1_idle", 64'(u_if.rrm_valid), 64'd0);

      // 2: channels 0,1,3 interleave with no bubble for idle channel 2
      do_reset();
      u_if.rr_valid = '0;
      base[0] = 64'h20; base[1] = 64'h40; base[2] = 64'h0; base[3] = 64'h60;
      order[0] = 0; order[1] = 1; order[2] = 3;
      load(0, 61'h100, 19'd24);
      load(1, 61'h200, 19'd24);
      load(3, 61'h300, 19'd24);
      for (int r = 0; r < 3; r++)
         for (int j = 0; j < 3; j++) push(order[j], base[order[j]] + 64'(r));
      u_if.rr_valid = 4'hF;
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t2_grant", 64'(u_if.rr_ready), 64'(4'b0001 << order[j]));
            tick();
            chk("t2_no_bubble", 64'(u_if.rrm_valid), 64'd1);
         end
      end
      wait_drain("t2_drain", 20);

      // 3: backpressure holds the request stable
      do_reset();
      u_if.rr_valid = 4'hF;
      for (int i = 0; i < 8; i++) push(0, 64'h10 + 64'(i));
      load(0, 61'h80, 19'd64);
      tick();
      tick();
      u_if.rrm_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_addr", 64'(u_if.rrm_addr), 64'h11);
         chk("t3_hold_tag", 64'(u_if.rrm_tag), 64'h01);
         chk("t3_no_grant", 64'(u_if.rr_ready), 64'd0);
         chk("t3_busy", 64'(u_if.busy), 64'h1);
         tick();
      end
      u_if.rrm_ready = 1'b1;
      wait_drain("t3_drain", 30);
      tick();
      chk("t3_idle", 64'(u_if.rrm_valid), 64'd0);

      // 4: tag starvation, then one-cycle latency once a tag appears
      do_reset();
      u_if.rr_valid = '0;
      push(1, 64'h80);
      push(1, 64'h81);
      load(1, 61'h400, 19'd16);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_no_valid", 64'(u_if.rrm_valid), 64'd0);
         chk("t4_busy1", 64'(u_if.busy[1]), 64'd1);
         tick();
      end
      u_if.rr_valid[1] = 1'b1;
      @(negedge clk);
      chk("t4_grant", 64'(u_if.rr_ready), 64'h2);
      tick();
      chk("t4_latency", 64'(u_if.rrm_valid), 64'd1);
      wait_drain("t4_drain", 20);

      // 5: abort after 5 grants on a 100-block range
      do_reset();
      u_if.rr_valid = 4'hF;
      for (int i = 0; i < 5; i++) push(2, 64'h100 + 64'(i));
      load(2, 61'h800, 19'd800);
      g = 0;
      n = 0;
      while (g < 5 && n < 50) begin
         @(negedge clk);
         if (u_if.rr_ready[2]) g++;
         tick();
         n++;
      end
      chk("t5_grants_before_abort", 64'(g), 64'd5);
      u_if.r_abort[2] = 1'b1;
      @(negedge clk);
      chk("t5_abort_no_grant", 64'(u_if.rr_ready), 64'd0);
      tick();
      u_if.r_abort = '0;
      chk("t5_busy2", 64'(u_if.busy[2]), 64'd0);
      chk("t5_r_ready2", 64'(u_if.r_ready[2]), 64'd1);
      wait_drain("t5_drain", 20);
      tick();
      tick();
      chk("t5_idle", 64'(u_if.rrm_valid), 64'd0);

      // 6: asynchronous reset with a request held, then ch0 first
      do_reset();
      u_if.rr_valid  = 4'hF;
      u_if.rrm_ready = 1'b0;
      load(1, 61'h1000, 19'd64);
      tick();
      chk("t6_held", 64'(u_if.rrm_valid), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 64'(u_if.rrm_valid), 64'd0);
      chk("t6_async_addr", 64'(u_if.rrm_addr), 64'd0);
      chk("t6_async_tag", 64'(u_if.rrm_tag), 64'd0);
      chk("t6_async_busy", 64'(u_if.busy), 64'd0);
      chk("t6_async_rr_ready", 64'(u_if.rr_ready), 64'd0);
      sb_q.delete();
      tick();
      tick();
      rst = 1'b0;
      u_if.rrm_ready = 1'b1;
      u_if.rr_valid  = '0;
      tick();
      load(1, 61'h1000, 19'd8);
      load(0, 61'h2000, 19'd8);
      push(0, 64'h400);
      push(1, 64'h200);
      u_if.rr_valid = 4'hF;
      @(negedge clk);
      chk("t6_first_ch0", 64'(u_if.rr_ready), 64'h1);
      tick();
      wait_drain("t6_drain", 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
